// File: rtl/mrd_rdx_p2s_if.sv
// Port bundle of the mixed-radix DFT parallel-to-serial output stage.
interface mrd_rdx_p2s_if #(
   parameter int wDataInOut = 30,
   parameter int DEPTH      = 4
);
   logic                                in_val;
   logic [2:0]                          in_radix;
   logic signed [wDataInOut-1:0]        din_real [0:4];
   logic signed [wDataInOut-1:0]        din_imag [0:4];
   logic                                out_ready;
   logic                                out_val;
   logic                                out_sop;
   logic                                out_eop;
   logic signed [wDataInOut-1:0]        dout_real;
   logic signed [wDataInOut-1:0]        dout_imag;
   logic [$clog2(DEPTH+1)-1:0]          fifo_level;
   logic                                in_overflow;

   modport master (
      output in_val, in_radix, din_real, din_imag, out_ready,
      input  out_val, out_sop, out_eop, dout_real, dout_imag,
      input  fifo_level, in_overflow
   );

   modport slave (
      input  in_val, in_radix, din_real, din_imag, out_ready,
      output out_val, out_sop, out_eop, dout_real, dout_imag,
      output fifo_level, in_overflow
   );
endinterface

// File: rtl/mrd_rdx_p2s.sv
// Buffers 5-lane butterfly vectors and emits them one lane per cycle.
// Optional MRD_P2S_ROUND_EN: round-half-up shift by SHIFT on the outputs.
module mrd_rdx_p2s #(
   parameter int wDataInOut = 30,
   parameter int DEPTH      = 4,
   parameter int SHIFT      = 2
) (
   input logic            clk,
   input logic            rst,
   mrd_rdx_p2s_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   typedef logic signed [wDataInOut-1:0] smp_t;
   typedef enum logic {IDLE, EMIT} st_t;

   if (SHIFT < 1 || DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_cfg
      $error("mrd_rdx_p2s: bad SHIFT/DEPTH");
   end

   smp_t       mem_re  [DEPTH][5];
   smp_t       mem_im  [DEPTH][5];
   logic [2:0] mem_rdx [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] cnt;
   logic       ovf;

   st_t        st;
   smp_t       e_re [5];
   smp_t       e_im [5];
   logic [2:0] e_rdx, lane, nxt;
   logic       val_q, sop_q, eop_q;
   smp_t       re_q, im_q;

   logic nempty, last, pop, push, adv, fin;

   function automatic logic [2:0] clamp(logic [2:0] r);
      if (r < 3'd2) return 3'd2;
      if (r > 3'd5) return 3'd5;
      return r;
   endfunction

   function automatic smp_t fmt(smp_t x);
`ifdef MRD_P2S_ROUND_EN
      logic signed [wDataInOut:0] t;
      t = {x[wDataInOut-1], x} + ((wDataInOut+1)'(1) <<< (SHIFT-1));
      return smp_t'(t >>> SHIFT);
`else
      return x;
`endif
   endfunction

   assign nempty = cnt != '0;
   assign nxt    = lane + 3'd1;
   assign last   = lane == e_rdx - 3'd1;
   // A pop either starts a vector from IDLE or chains with no bubble.
   assign pop    = nempty && (st == IDLE || (bus.out_ready && last));
   assign adv    = st == EMIT && bus.out_ready && !last;
   assign fin    = st == EMIT && bus.out_ready && last && !nempty;
   assign push   = bus.in_val && (cnt != LW'(DEPTH) || pop);

   always_ff @(posedge clk) begin
      if (push) begin
         for (int k = 0; k < 5; k++) begin
            mem_re[wr_ptr][k] <= bus.din_real[k];
            mem_im[wr_ptr][k] <= bus.din_imag[k];
         end
         mem_rdx[wr_ptr] <= clamp(bus.in_radix);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (push && !pop) cnt <= cnt + LW'(1);
         else if (pop && !push) cnt <= cnt - LW'(1);
         if (bus.in_val && !push) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= IDLE;
         rd_ptr <= '0;
         lane   <= '0;
         e_rdx  <= 3'd2;
         val_q  <= 1'b0;
         sop_q  <= 1'b0;
         eop_q  <= 1'b0;
         re_q   <= '0;
         im_q   <= '0;
      end else begin
         unique case (1'b1)
            pop: begin
               for (int k = 0; k < 5; k++) begin
                  e_re[k] <= mem_re[rd_ptr][k];
                  e_im[k] <= mem_im[rd_ptr][k];
               end
               e_rdx  <= mem_rdx[rd_ptr];
               rd_ptr <= rd_ptr + AW'(1);
               lane   <= '0;
               val_q  <= 1'b1;
               sop_q  <= 1'b1;
               eop_q  <= 1'b0;
               re_q   <= fmt(mem_re[rd_ptr][0]);
               im_q   <= fmt(mem_im[rd_ptr][0]);
               st     <= EMIT;
            end
            adv: begin
               lane  <= nxt;
               sop_q <= 1'b0;
               eop_q <= nxt == e_rdx - 3'd1;
               re_q  <= fmt(e_re[nxt]);
               im_q  <= fmt(e_im[nxt]);
            end
            fin: begin
               val_q <= 1'b0;
               sop_q <= 1'b0;
               eop_q <= 1'b0;
               st    <= IDLE;
            end
            default: ;
         endcase
      end
   end

   assign bus.out_val     = val_q;
   assign bus.out_sop     = sop_q;
   assign bus.out_eop     = eop_q;
   assign bus.dout_real   = re_q;
   assign bus.dout_imag   = im_q;
   assign bus.fifo_level  = cnt;
   assign bus.in_overflow = ovf;
endmodule
